// File: rtl/manycore_xcel_endpoint_pkg.sv
// Shared types for the accelerator mesh endpoint: opcodes, return types
// and the global-address region decode.
package manycore_xcel_endpoint_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_STORE = 2'd1
    } op_e;

    typedef enum logic {
        RET_LOAD_DATA    = 1'b0,
        RET_STORE_CREDIT = 1'b1
    } ret_type_e;

    typedef enum logic [1:0] {
        REGION_LOCAL  = 2'd0,
        REGION_GLOBAL = 2'd1,
        REGION_DRAM   = 2'd2
    } region_e;

    localparam int         ADDR_BITS     = 32;
    localparam int         DRAM_BIT      = 31;
    localparam logic [1:0] GLOBAL_PREFIX = 2'b01;

    function automatic region_e decode_region(input logic [ADDR_BITS-1:0] addr);
        if (addr[DRAM_BIT])
            return REGION_DRAM;
        if (addr[ADDR_BITS-1 -: 2] == GLOBAL_PREFIX)
            return REGION_GLOBAL;
        return REGION_LOCAL;
    endfunction

endpackage

// File: rtl/endpoint_fifo.sv
// Parameterized 1-read 1-write FIFO: valid/ready on the write side,
// valid/yumi on the read side, plus a free-slot count.
module endpoint_fifo #(
    parameter  int width_p  = 8,
    parameter  int els_p    = 4,
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int cnt_w_lp = $clog2(els_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                v_i,
    input  logic [width_p-1:0]  data_i,
    output logic                ready_o,
    output logic                v_o,
    output logic [width_p-1:0]  data_o,
    input  logic                yumi_i,
    output logic [cnt_w_lp-1:0] free_o
);

    logic [width_p-1:0]  mem [els_p];
    logic [ptr_w_lp-1:0] wr_ptr, rd_ptr;
    logic [cnt_w_lp-1:0] count;
    logic                push, pop;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    // A full FIFO refuses a push even when it is popped in the same cycle.
    assign ready_o = (count != cnt_w_lp'(els_p));
    assign v_o     = (count != '0);
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;
    assign data_o  = mem[rd_ptr];
    assign free_o  = cnt_w_lp'(els_p) - count;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                count <= count + cnt_w_lp'(1);
            else if (pop && !push)
                count <= count - cnt_w_lp'(1);
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/manycore_xcel_endpoint.sv
// Accelerator-tile mesh endpoint: slave CSR request/response path, master
// load/store encoder with credit flow control, and the returned-load queue.
module manycore_xcel_endpoint
    import manycore_xcel_endpoint_pkg::*;
#(
    parameter  int x_cord_width_p        = 4,
    parameter  int y_cord_width_p        = 4,
    parameter  int data_width_p          = 32,
    parameter  int addr_width_p          = 32,
    parameter  int load_id_width_p       = 11,
    parameter  int fifo_els_p            = 4,
    parameter  int max_out_credits_p     = 200,
    parameter  int epa_byte_addr_width_p = 18,
    parameter  int dram_ch_addr_width_p  = 16,
    parameter  int dram_ch_start_col_p   = 2,
    localparam int req_pkt_width_lp = addr_width_p + 2 + 4 + data_width_p
                                      + 2 * (x_cord_width_p + y_cord_width_p),
    localparam int ret_pkt_width_lp = 1 + data_width_p + load_id_width_p
                                      + x_cord_width_p + y_cord_width_p,
    localparam int link_width_lp    = req_pkt_width_lp + ret_pkt_width_lp + 4,
    localparam int credit_width_lp  = $clog2(max_out_credits_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic [link_width_lp-1:0]   link_sif_i,
    output logic [link_width_lp-1:0]   link_sif_o,

    input  logic [x_cord_width_p-1:0]  my_x_i,
    input  logic [y_cord_width_p-1:0]  my_y_i,

    output logic                       in_v_o,
    input  logic                       in_yumi_i,
    output logic [data_width_p-1:0]    in_data_o,
    output logic [3:0]                 in_mask_o,
    output logic [addr_width_p-1:0]    in_addr_o,
    output logic                       in_we_o,
    output logic [x_cord_width_p-1:0]  in_src_x_cord_o,
    output logic [y_cord_width_p-1:0]  in_src_y_cord_o,

    input  logic                       returning_v_i,
    input  logic [data_width_p-1:0]    returning_data_i,

    input  logic                       out_v_i,
    input  logic [31:0]                out_addr_i,
    input  logic [data_width_p-1:0]    out_data_i,
    input  logic [3:0]                 out_mask_i,
    input  logic                       out_we_i,
    input  logic [load_id_width_p-1:0] out_load_id_i,
    output logic                       out_ready_o,

    output logic                       returned_v_r_o,
    output logic [data_width_p-1:0]    returned_data_r_o,
    output logic [load_id_width_p-1:0] returned_load_id_r_o,
    input  logic                       returned_yumi_i,
    output logic                       returned_fifo_full_o,

    output logic [credit_width_lp-1:0] out_credits_o
);

    localparam int fifo_cnt_w_lp = $clog2(fifo_els_p + 1);
    localparam int epa_word_w_lp = epa_byte_addr_width_p - 2;

    typedef struct packed {
        logic [addr_width_p-1:0]   addr;
        op_e                       op;
        logic [3:0]                mask;
        logic [data_width_p-1:0]   payload;
        logic [y_cord_width_p-1:0] src_y;
        logic [x_cord_width_p-1:0] src_x;
        logic [y_cord_width_p-1:0] y_cord;
        logic [x_cord_width_p-1:0] x_cord;
    } req_pkt_s;

    typedef struct packed {
        ret_type_e                  pkt_type;
        logic [data_width_p-1:0]    data;
        logic [load_id_width_p-1:0] load_id;
        logic [y_cord_width_p-1:0]  y_cord;
        logic [x_cord_width_p-1:0]  x_cord;
    } ret_pkt_s;

    typedef struct packed {
        logic     fwd_v;
        req_pkt_s fwd_pkt;
        logic     fwd_ready;
        logic     rev_v;
        ret_pkt_s rev_pkt;
        logic     rev_ready;
    } link_sif_s;

    typedef struct packed {
        logic [data_width_p-1:0]    data;
        logic [load_id_width_p-1:0] load_id;
    } returned_s;

    link_sif_s link_in, link_out;
    assign link_in    = link_sif_i;
    assign link_sif_o = link_out;

    // ---------------- slave side ----------------
    req_pkt_s                   req_head;
    logic                       req_v, req_ready;
    logic [fifo_cnt_w_lp-1:0]   req_free;
    ret_pkt_s                   ret_enq, ret_head;
    logic                       ret_v, ret_ready;
    logic [fifo_cnt_w_lp-1:0]   ret_free;
    logic [x_cord_width_p-1:0]  src_x_r;
    logic [y_cord_width_p-1:0]  src_y_r;
    op_e                        op_r;
    logic [load_id_width_p-1:0] load_id_r;

    endpoint_fifo #(.width_p(req_pkt_width_lp), .els_p(fifo_els_p)) req_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (link_in.fwd_v),
        .data_i  (link_in.fwd_pkt),
        .ready_o (req_ready),
        .v_o     (req_v),
        .data_o  (req_head),
        .yumi_i  (in_yumi_i),
        .free_o  (req_free)
    );

    // Two free return slots: one may already be owed to a popped request.
    assign in_v_o          = req_v && (ret_free >= fifo_cnt_w_lp'(2));
    assign in_data_o       = req_head.payload;
    assign in_mask_o       = req_head.mask;
    assign in_addr_o       = req_head.addr;
    assign in_we_o         = (req_head.op == OP_STORE);
    assign in_src_x_cord_o = req_head.src_x;
    assign in_src_y_cord_o = req_head.src_y;

    always_ff @(posedge clk_i) begin
        if (in_yumi_i) begin
            src_x_r   <= req_head.src_x;
            src_y_r   <= req_head.src_y;
            op_r      <= req_head.op;
            load_id_r <= req_head.payload[load_id_width_p-1:0];
        end
    end

    always_comb begin
        ret_enq.pkt_type = (op_r == OP_STORE) ? RET_STORE_CREDIT : RET_LOAD_DATA;
        ret_enq.data     = (op_r == OP_STORE) ? '0 : returning_data_i;
        ret_enq.load_id  = load_id_r;
        ret_enq.y_cord   = src_y_r;
        ret_enq.x_cord   = src_x_r;
    end

    endpoint_fifo #(.width_p(ret_pkt_width_lp), .els_p(fifo_els_p)) ret_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (returning_v_i),
        .data_i  (ret_enq),
        .ready_o (ret_ready),
        .v_o     (ret_v),
        .data_o  (ret_head),
        .yumi_i  (ret_v & link_in.rev_ready),
        .free_o  (ret_free)
    );

    // ---------------- master side ----------------
    req_pkt_s                   out_pkt;
    region_e                    region;
    logic                       send, rev_accept;
    logic [credit_width_lp-1:0] credits;
    logic                       returned_ready;
    returned_s                  returned_enq, returned_head;
    logic [fifo_cnt_w_lp-1:0]   returned_free;

    // NOTE: every field gets a value before the case so no latch is inferred.
    always_comb begin
        region          = decode_region(out_addr_i);
        out_pkt.op      = out_we_i ? OP_STORE : OP_LOAD;
        out_pkt.mask    = out_mask_i;
        out_pkt.payload = out_we_i ? out_data_i : data_width_p'(out_load_id_i);
        out_pkt.src_x   = my_x_i;
        out_pkt.src_y   = my_y_i;
        out_pkt.x_cord  = my_x_i;
        out_pkt.y_cord  = my_y_i;
        out_pkt.addr    = addr_width_p'(out_addr_i >> 2);
        case (region)
            REGION_DRAM: begin
                out_pkt.x_cord = x_cord_width_p'(dram_ch_start_col_p)
                               + out_addr_i[2+dram_ch_addr_width_p +: x_cord_width_p];
                out_pkt.y_cord = '1;
                out_pkt.addr   = addr_width_p'(out_addr_i[2 +: dram_ch_addr_width_p]);
            end
            REGION_GLOBAL: begin
                out_pkt.x_cord = out_addr_i[2+epa_word_w_lp +: x_cord_width_p];
                out_pkt.y_cord = out_addr_i[2+epa_word_w_lp+x_cord_width_p +: y_cord_width_p];
                out_pkt.addr   = addr_width_p'(out_addr_i[2 +: epa_word_w_lp]);
            end
            default: ;
        endcase
    end

    assign out_ready_o = link_in.fwd_ready && (credits != '0);
    assign send        = out_v_i && out_ready_o;
    assign rev_accept  = link_in.rev_v && returned_ready;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            credits <= credit_width_lp'(max_out_credits_p);
        else if (send && !rev_accept)
            credits <= credits - credit_width_lp'(1);
        else if (!send && rev_accept && credits != credit_width_lp'(max_out_credits_p))
            credits <= credits + credit_width_lp'(1);
    end
    assign out_credits_o = credits;

    assign returned_enq.data    = link_in.rev_pkt.data;
    assign returned_enq.load_id = link_in.rev_pkt.load_id;

    endpoint_fifo #(.width_p(data_width_p + load_id_width_p), .els_p(fifo_els_p)) returned_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (rev_accept && link_in.rev_pkt.pkt_type == RET_LOAD_DATA),
        .data_i  (returned_enq),
        .ready_o (returned_ready),
        .v_o     (returned_v_r_o),
        .data_o  (returned_head),
        .yumi_i  (returned_yumi_i),
        .free_o  (returned_free)
    );

    assign returned_data_r_o    = returned_head.data;
    assign returned_load_id_r_o = returned_head.load_id;
    assign returned_fifo_full_o = !returned_ready;

    always_comb begin
        link_out.fwd_v     = send;
        link_out.fwd_pkt   = out_pkt;
        link_out.fwd_ready = req_ready;
        link_out.rev_v     = ret_v;
        link_out.rev_pkt   = ret_head;
        link_out.rev_ready = returned_ready;
    end

    logic unused;
    assign unused = ^{req_head.x_cord, req_head.y_cord, link_in.rev_pkt.x_cord,
                      link_in.rev_pkt.y_cord, req_free, returned_free, ret_ready,
                      out_addr_i[1:0]};

endmodule

// File: tb/tb_manycore_xcel_endpoint.sv
// Directed self-checking bench for manycore_xcel_endpoint.
module tb_manycore_xcel_endpoint;

    localparam int XW = 4, YW = 4, DW = 32, AW = 32, LW = 11;
    localparam int ELS = 4, MAXC = 200, EPAW = 18, DCHW = 16, DCOL = 2;
    localparam int REQW  = AW + 2 + 4 + DW + 2 * (XW + YW);
    localparam int RETW  = 1 + DW + LW + XW + YW;
    localparam int LINKW = REQW + RETW + 4;
    localparam int CW    = $clog2(MAXC + 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    op;
        logic [3:0]    mask;
        logic [DW-1:0] payload;
        logic [YW-1:0] src_y;
        logic [XW-1:0] src_x;
        logic [YW-1:0] y_cord;
        logic [XW-1:0] x_cord;
    } req_t;

    typedef struct packed {
        logic          pkt_type;
        logic [DW-1:0] data;
        logic [LW-1:0] load_id;
        logic [YW-1:0] y_cord;
        logic [XW-1:0] x_cord;
    } ret_t;

    typedef struct packed {
        logic fwd_v;
        req_t fwd_pkt;
        logic fwd_ready;
        logic rev_v;
        ret_t rev_pkt;
        logic rev_ready;
    } link_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_i;
    link_t            lin, lout;
    logic [LINKW-1:0] link_sif_o;
    logic [XW-1:0]    my_x;
    logic [YW-1:0]    my_y;
    logic             in_v_o, in_yumi_i, in_we_o;
    logic [DW-1:0]    in_data_o;
    logic [3:0]       in_mask_o;
    logic [AW-1:0]    in_addr_o;
    logic [XW-1:0]    in_src_x_cord_o;
    logic [YW-1:0]    in_src_y_cord_o;
    logic             returning_v_i;
    logic [DW-1:0]    returning_data_i;
    logic             out_v_i, out_we_i, out_ready_o;
    logic [31:0]      out_addr_i;
    logic [DW-1:0]    out_data_i;
    logic [3:0]       out_mask_i;
    logic [LW-1:0]    out_load_id_i;
    logic             returned_v_r_o, returned_yumi_i, returned_fifo_full_o;
    logic [DW-1:0]    returned_data_r_o;
    logic [LW-1:0]    returned_load_id_r_o;
    logic [CW-1:0]    out_credits_o;

    assign lout = link_sif_o;

    manycore_xcel_endpoint #(
        .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW),
        .addr_width_p(AW), .load_id_width_p(LW), .fifo_els_p(ELS),
        .max_out_credits_p(MAXC), .epa_byte_addr_width_p(EPAW),
        .dram_ch_addr_width_p(DCHW), .dram_ch_start_col_p(DCOL)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .link_sif_i(lin), .link_sif_o(link_sif_o),
        .my_x_i(my_x), .my_y_i(my_y),
        .in_v_o(in_v_o), .in_yumi_i(in_yumi_i), .in_data_o(in_data_o),
        .in_mask_o(in_mask_o), .in_addr_o(in_addr_o), .in_we_o(in_we_o),
        .in_src_x_cord_o(in_src_x_cord_o), .in_src_y_cord_o(in_src_y_cord_o),
        .returning_v_i(returning_v_i), .returning_data_i(returning_data_i),
        .out_v_i(out_v_i), .out_addr_i(out_addr_i), .out_data_i(out_data_i),
        .out_mask_i(out_mask_i), .out_we_i(out_we_i), .out_load_id_i(out_load_id_i),
        .out_ready_o(out_ready_o),
        .returned_v_r_o(returned_v_r_o), .returned_data_r_o(returned_data_r_o),
        .returned_load_id_r_o(returned_load_id_r_o), .returned_yumi_i(returned_yumi_i),
        .returned_fifo_full_o(returned_fifo_full_o),
        .out_credits_o(out_credits_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic req_t mk_req(input logic [1:0] op, input logic [31:0] addr,
                                    input logic [31:0] payload,
                                    input logic [3:0] sx, input logic [3:0] sy);
        req_t r;
        r.addr = addr;  r.op = op;  r.mask = 4'hF;  r.payload = payload;
        r.src_y = sy;   r.src_x = sx;
        r.y_cord = 4'd6; r.x_cord = 4'd5;
        return r;
    endfunction

    function automatic ret_t mk_ret(input logic t, input logic [31:0] d, input logic [10:0] id);
        ret_t r;
        r.pkt_type = t; r.data = d; r.load_id = id; r.y_cord = 4'd6; r.x_cord = 4'd5;
        return r;
    endfunction

    // One slave transaction: request in, pop it, answer one cycle later.
    task automatic slave_rt(input string tag, input req_t r, input logic [31:0] rdata);
        lin.fwd_v   = 1'b1;
        lin.fwd_pkt = r;
        step();
        lin.fwd_v = 1'b0;
        check({tag, "_in_v"}, in_v_o, 1);
        check({tag, "_we"}, in_we_o, (r.op == 2'd1));
        check({tag, "_data"}, in_data_o, r.payload);
        check({tag, "_addr"}, in_addr_o, r.addr);
        check({tag, "_src"}, {in_src_y_cord_o, in_src_x_cord_o}, {r.src_y, r.src_x});
        in_yumi_i = 1'b1;
        step();
        in_yumi_i        = 1'b0;
        returning_v_i    = 1'b1;
        returning_data_i = rdata;
        step();
        returning_v_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_i = 1'b1;
        lin = '0;
        lin.fwd_ready = 1'b1;
        lin.rev_ready = 1'b1;
        my_x = 4'd5; my_y = 4'd6;
        in_yumi_i = 0; returning_v_i = 0; returning_data_i = '0;
        out_v_i = 0; out_we_i = 0; out_addr_i = '0; out_data_i = '0;
        out_mask_i = 4'hF; out_load_id_i = '0; returned_yumi_i = 0;
        step(3);
        reset_i = 1'b0;

        check("rst_in_v", in_v_o, 0);
        check("rst_returned_v", returned_v_r_o, 0);
        check("rst_fwd_v", lout.fwd_v, 0);
        check("rst_rev_v", lout.rev_v, 0);
        check("rst_fwd_ready", lout.fwd_ready, 1);
        check("rst_rev_ready", lout.rev_ready, 1);
        check("rst_credits", out_credits_o, 200);
        check("rst_full", returned_fifo_full_o, 0);

        // Store CSR
        slave_rt("st", mk_req(2'd1, 32'h10, 32'hCAFE, 4'd1, 4'd2), 32'h5555);
        check("st_rev_v", lout.rev_v, 1);
        check("st_rev_type", lout.rev_pkt.pkt_type, 1);
        check("st_rev_dest", {lout.rev_pkt.y_cord, lout.rev_pkt.x_cord}, {4'd2, 4'd1});
        check("st_rev_data", lout.rev_pkt.data, 0);
        check("st_in_v_after_pop", in_v_o, 0);
        step();
        check("st_rev_drained", lout.rev_v, 0);

        // Load CSR
        slave_rt("ld", mk_req(2'd0, 32'h20, 32'd5, 4'd3, 4'd1), 32'h1234);
        check("ld_rev_v", lout.rev_v, 1);
        check("ld_rev_type", lout.rev_pkt.pkt_type, 0);
        check("ld_rev_data", lout.rev_pkt.data, 32'h1234);
        check("ld_rev_id", lout.rev_pkt.load_id, 5);
        check("ld_rev_dest", {lout.rev_pkt.y_cord, lout.rev_pkt.x_cord}, {4'd1, 4'd3});
        step();

        // in_v_o needs two free return slots
        lin.rev_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            slave_rt("gate", mk_req(2'd0, 32'h30, 32'd0, 4'd1, 4'd1), 32'h100 + k);
        lin.fwd_v   = 1'b1;
        lin.fwd_pkt = mk_req(2'd0, 32'h34, 32'd0, 4'd1, 4'd1);
        step();
        lin.fwd_v = 1'b0;
        check("gate_in_v_low", in_v_o, 0);
        check("gate_rev_head", lout.rev_pkt.data, 32'h100);
        lin.rev_ready = 1'b1;
        step();
        check("gate_in_v_high", in_v_o, 1);
        check("gate_rev_next", lout.rev_pkt.data, 32'h101);
        in_yumi_i = 1'b1;
        step();
        in_yumi_i = 1'b0; returning_v_i = 1'b1; returning_data_i = 32'h200;
        step();
        returning_v_i = 1'b0;
        step(4);
        check("gate_drained", lout.rev_v, 0);

        // Master DRAM load
        out_v_i = 1; out_addr_i = 32'h8000_0040; out_we_i = 0;
        out_load_id_i = 11'd7; out_data_i = 32'hDEAD;
        #1;
        check("dram_ready", out_ready_o, 1);
        check("dram_fwd_v", lout.fwd_v, 1);
        check("dram_x", lout.fwd_pkt.x_cord, DCOL);
        check("dram_y", lout.fwd_pkt.y_cord, 4'hF);
        check("dram_epa", lout.fwd_pkt.addr, 32'h10);
        check("dram_op", lout.fwd_pkt.op, 0);
        check("dram_payload", lout.fwd_pkt.payload, 7);
        check("dram_src", {lout.fwd_pkt.src_y, lout.fwd_pkt.src_x}, {4'd6, 4'd5});
        step();
        out_v_i = 0;
        check("dram_credits_dec", out_credits_o, 199);
        lin.rev_v = 1'b1; lin.rev_pkt = mk_ret(1'b0, 32'hAB, 11'd7);
        #1;
        check("dram_rev_ready", lout.rev_ready, 1);
        step();
        lin.rev_v = 1'b0;
        check("dram_returned_v", returned_v_r_o, 1);
        check("dram_returned_data", returned_data_r_o, 32'hAB);
        check("dram_returned_id", returned_load_id_r_o, 7);
        check("dram_credits_back", out_credits_o, 200);
        returned_yumi_i = 1'b1;
        step();
        returned_yumi_i = 1'b0;
        check("dram_returned_pop", returned_v_r_o, 0);

        // Global and local encodes
        out_v_i = 1; out_we_i = 1; out_data_i = 32'h77;
        out_addr_i = 32'h4000_0000 | (32'd3 << 22) | (32'd9 << 18) | (32'h123 << 2);
        #1;
        check("glb_x", lout.fwd_pkt.x_cord, 9);
        check("glb_y", lout.fwd_pkt.y_cord, 3);
        check("glb_epa", lout.fwd_pkt.addr, 32'h123);
        check("glb_op", lout.fwd_pkt.op, 1);
        check("glb_payload", lout.fwd_pkt.payload, 32'h77);
        step();
        check("glb_credits", out_credits_o, 199);
        out_addr_i = 32'h0000_0100;
        lin.rev_v = 1'b1; lin.rev_pkt = mk_ret(1'b1, 32'h0, 11'd0);
        #1;
        check("loc_xy", {lout.fwd_pkt.y_cord, lout.fwd_pkt.x_cord}, {4'd6, 4'd5});
        check("loc_epa", lout.fwd_pkt.addr, 32'h40);
        step();
        out_v_i = 0; lin.rev_v = 1'b0;
        check("credits_same_cycle", out_credits_o, 199);
        check("type1_not_queued", returned_v_r_o, 0);

        // Remote not ready blocks sends
        lin.fwd_ready = 1'b0; out_v_i = 1;
        #1;
        check("remote_block_ready", out_ready_o, 0);
        check("remote_block_fwd_v", lout.fwd_v, 0);
        lin.fwd_ready = 1'b1;

        // Credit exhaustion
        step(199);
        check("exhaust_credits", out_credits_o, 0);
        check("exhaust_ready", out_ready_o, 0);
        check("exhaust_fwd_v", lout.fwd_v, 0);
        lin.rev_v = 1'b1; lin.rev_pkt = mk_ret(1'b1, 32'h0, 11'd0);
        step();
        lin.rev_v = 1'b0;
        check("one_credit", out_credits_o, 1);
        check("one_credit_ready", out_ready_o, 1);
        check("one_credit_no_data", returned_v_r_o, 0);
        out_v_i = 0;

        // Saturation
        lin.rev_v = 1'b1;
        step(199);
        check("credits_full", out_credits_o, 200);
        step();
        lin.rev_v = 1'b0;
        check("credits_saturate", out_credits_o, 200);

        // Returned FIFO fills
        lin.rev_v = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lin.rev_pkt = mk_ret(1'b0, 32'hD0 + k, 11'(k));
            step();
        end
        check("ret_full", returned_fifo_full_o, 1);
        check("ret_full_rev_ready", lout.rev_ready, 0);
        lin.rev_pkt = mk_ret(1'b0, 32'hE0, 11'd9);
        step();
        lin.rev_v = 1'b0;
        check("ret_full_head", returned_data_r_o, 32'hD0);
        returned_yumi_i = 1'b1;
        step();
        returned_yumi_i = 1'b0;
        check("ret_unfull", returned_fifo_full_o, 0);
        check("ret_next_head", returned_data_r_o, 32'hD1);
        check("ret_next_id", returned_load_id_r_o, 1);
        returned_yumi_i = 1'b1;
        step(3);
        returned_yumi_i = 1'b0;
        check("ret_emptied", returned_v_r_o, 0);

        // Request backpressure
        lin.fwd_v = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lin.fwd_pkt = mk_req(2'd1, 32'h40 + k, 32'hB0 + k, 4'd1, 4'd1);
            check("bp_ready", lout.fwd_ready, 1);
            step();
        end
        lin.fwd_pkt = mk_req(2'd1, 32'h44, 32'hB4, 4'd1, 4'd1);
        check("bp_full", lout.fwd_ready, 0);
        check("bp_head", in_data_o, 32'hB0);
        step();
        check("bp_still_full", lout.fwd_ready, 0);
        in_yumi_i = 1'b1;
        step();
        in_yumi_i = 1'b0; returning_v_i = 1'b1; returning_data_i = '0;
        check("bp_reraise", lout.fwd_ready, 1);
        step();
        lin.fwd_v = 1'b0; returning_v_i = 1'b0;
        check("bp_refull", lout.fwd_ready, 0);
        check("bp_next_head", in_data_o, 32'hB1);

        // Reset mid-operation
        lin.rev_v = 1'b1; lin.rev_pkt = mk_ret(1'b0, 32'h99, 11'd3);
        step();
        lin.rev_v = 1'b0; out_v_i = 1'b1;
        step();
        out_v_i = 1'b0;
        check("pre_rst_credits", out_credits_o, 199);
        check("pre_rst_returned", returned_v_r_o, 1);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("mid_rst_in_v", in_v_o, 0);
        check("mid_rst_returned", returned_v_r_o, 0);
        check("mid_rst_credits", out_credits_o, 200);
        check("mid_rst_fwd_ready", lout.fwd_ready, 1);
        check("mid_rst_rev_v", lout.rev_v, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
